// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR channel arbiter.
package ddr_arb_pkg;

    localparam int DEF_INDEX_W = 19;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_LINE_W  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        CH_PC = 2'd0,
        CH_LD = 2'd1,
        CH_ST = 2'd2
    } ch_t;

endpackage

// File: rtl/ddr_arb_picker.sv
// Three-way grant select over st/ld/pc. Fixed priority st > ld > pc by default;
// round-robin with a last-granted pointer when DDR_ARB_ROUND_ROBIN_EN is defined.
module ddr_arb_picker
    import ddr_arb_pkg::*;
(
`ifdef DDR_ARB_ROUND_ROBIN_EN
    input  logic clock,
    input  logic reset_n,
    input  logic advance,
`endif
    input  logic st_req,
    input  logic ld_req,
    input  logic pc_req,
    output logic any_req,
    output ch_t  grant
);

`ifdef DDR_ARB_ROUND_ROBIN_EN
    ch_t last_q;

    // Reset value "pc last" makes st the highest priority after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= CH_PC;
        end else if (advance) begin
            last_q <= grant;
        end
    end

    always_comb begin
        grant = CH_PC;
        case (last_q)
            CH_ST: begin
                if (ld_req)      grant = CH_LD;
                else if (pc_req) grant = CH_PC;
                else if (st_req) grant = CH_ST;
            end
            CH_LD: begin
                if (pc_req)      grant = CH_PC;
                else if (st_req) grant = CH_ST;
                else if (ld_req) grant = CH_LD;
            end
            default: begin
                if (st_req)      grant = CH_ST;
                else if (ld_req) grant = CH_LD;
                else if (pc_req) grant = CH_PC;
            end
        endcase
    end
`else
    always_comb begin
        grant = CH_PC;
        if (st_req)      grant = CH_ST;
        else if (ld_req) grant = CH_LD;
    end
`endif

    assign any_req = st_req | ld_req | pc_req;

endmodule

// File: rtl/ddr_channel_arbiter.sv
// Arbitrates instruction-burst, load and store channels onto one DDR port.
// Optional round-robin arbitration via DDR_ARB_ROUND_ROBIN_EN.
//
// state | meaning
// IDLE  | waiting for a request while DDR is ready; grant registered on exit
// ISSUE | chip_enable pulse with registered payload
// WAIT  | payload held until ddr_operation_done; read data captured on exit
// RESP  | done pulse of the granted channel (pc suppressed if flushed)
module ddr_channel_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LINE_W  = DEF_LINE_W
) (
    input  logic               clock,
    input  logic               reset_n,

    input  logic               pc_req,
    input  logic [INDEX_W-1:0] pc_index,
    input  logic               pc_flush,
    output logic               pc_done,
    output logic [LINE_W-1:0]  pc_line,

    input  logic               ld_req,
    input  logic [INDEX_W-1:0] ld_index,
    output logic               ld_done,
    output logic [DATA_W-1:0]  ld_data,

    input  logic               st_req,
    input  logic [INDEX_W-1:0] st_index,
    input  logic [DATA_W-1:0]  st_mask,
    input  logic [DATA_W-1:0]  st_data,
    output logic               st_done,

    output logic               ddr_chip_enable,
    output logic [INDEX_W-1:0] ddr_index,
    output logic               ddr_write_enable,
    output logic               ddr_burst_mode,
    output logic [DATA_W-1:0]  ddr_opstore_write_mask,
    output logic [DATA_W-1:0]  ddr_opstore_write_data,
    input  logic [DATA_W-1:0]  ddr_opload_read_data,
    input  logic [LINE_W-1:0]  ddr_pc_read_inst,
    input  logic               ddr_operation_done,
    input  logic               ddr_ready
);

    arb_state_t         state_q, state_d;
    ch_t                grant_q;
    ch_t                pick;
    logic               any_req;
    logic               take;
    logic [INDEX_W-1:0] index_q;
    logic [DATA_W-1:0]  mask_q, data_q;
    logic               we_q, burst_q, flush_q;
    logic [DATA_W-1:0]  ld_data_q;
    logic [LINE_W-1:0]  pc_line_q;

    assign take = (state_q == IDLE) && any_req && ddr_ready;

    ddr_arb_picker u_picker (
`ifdef DDR_ARB_ROUND_ROBIN_EN
        .clock   (clock),
        .reset_n (reset_n),
        .advance (take),
`endif
        .st_req  (st_req),
        .ld_req  (ld_req),
        .pc_req  (pc_req),
        .any_req (any_req),
        .grant   (pick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ddr_operation_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ddr_chip_enable = 1'b0;
        st_done         = 1'b0;
        ld_done         = 1'b0;
        pc_done         = 1'b0;
        case (state_q)
            ISSUE: ddr_chip_enable = 1'b1;
            RESP: begin
                st_done = (grant_q == CH_ST);
                ld_done = (grant_q == CH_LD);
                pc_done = (grant_q == CH_PC) && !flush_q;
            end
            default: ;
        endcase
    end

    // Payload is held from the grant edge until the next grant, which keeps
    // the DDR side stable across ISSUE and WAIT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= CH_PC;
            index_q <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            flush_q <= 1'b0;
        end else if (take) begin
            grant_q <= pick;
            we_q    <= (pick == CH_ST);
            burst_q <= (pick == CH_PC);
            flush_q <= 1'b0;
            case (pick)
                CH_ST: begin
                    index_q <= st_index;
                    mask_q  <= st_mask;
                    data_q  <= st_data;
                end
                CH_LD: begin
                    index_q <= ld_index;
                    mask_q  <= '0;
                    data_q  <= '0;
                end
                default: begin
                    index_q <= pc_index;
                    mask_q  <= '0;
                    data_q  <= '0;
                end
            endcase
        end else if ((state_q == ISSUE || state_q == WAIT) && grant_q == CH_PC && pc_flush) begin
            flush_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ld_data_q <= '0;
            pc_line_q <= '0;
        end else if (state_q == WAIT && ddr_operation_done) begin
            if (grant_q == CH_LD) ld_data_q <= ddr_opload_read_data;
            if (grant_q == CH_PC) pc_line_q <= ddr_pc_read_inst;
        end
    end

    assign ddr_index              = index_q;
    assign ddr_write_enable       = we_q;
    assign ddr_burst_mode         = burst_q;
    assign ddr_opstore_write_mask = mask_q;
    assign ddr_opstore_write_data = data_q;
    assign ld_data                = ld_data_q;
    assign pc_line                = pc_line_q;

endmodule

// File: tb/tb_ddr_channel_arbiter.sv
// Directed self-checking bench for ddr_channel_arbiter; covers both the fixed
// and DDR_ARB_ROUND_ROBIN_EN builds.
module tb_ddr_channel_arbiter;
    import ddr_arb_pkg::*;

    localparam int INDEX_W = 19;
    localparam int DATA_W  = 64;
    localparam int LINE_W  = 512;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               pc_req, pc_flush, pc_done;
    logic [INDEX_W-1:0] pc_index;
    logic [LINE_W-1:0]  pc_line;
    logic               ld_req, ld_done;
    logic [INDEX_W-1:0] ld_index;
    logic [DATA_W-1:0]  ld_data;
    logic               st_req, st_done;
    logic [INDEX_W-1:0] st_index;
    logic [DATA_W-1:0]  st_mask, st_data;
    logic               ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
    logic [INDEX_W-1:0] ddr_index;
    logic [DATA_W-1:0]  ddr_opstore_write_mask, ddr_opstore_write_data;
    logic [DATA_W-1:0]  ddr_opload_read_data;
    logic [LINE_W-1:0]  ddr_pc_read_inst;
    logic               ddr_operation_done, ddr_ready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ddr_channel_arbiter dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .pc_req                 (pc_req),
        .pc_index               (pc_index),
        .pc_flush               (pc_flush),
        .pc_done                (pc_done),
        .pc_line                (pc_line),
        .ld_req                 (ld_req),
        .ld_index               (ld_index),
        .ld_done                (ld_done),
        .ld_data                (ld_data),
        .st_req                 (st_req),
        .st_index               (st_index),
        .st_mask                (st_mask),
        .st_data                (st_data),
        .st_done                (st_done),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the ISSUE pulse, plays a DDR with `lat` cycles of latency and
    // checks the response cycle. Returns in IDLE after RESP.
    task automatic serve(input ch_t ch, input logic [INDEX_W-1:0] idx, input int lat,
                         input logic flush, input logic drop, input logic [LINE_W-1:0] exp_rd);
        bit seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (ddr_chip_enable) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("ce_seen", 1'(seen), 1'b1);
        chk("issue_we", ddr_write_enable, 1'(ch == CH_ST));
        chk("issue_burst", ddr_burst_mode, 1'(ch == CH_PC));
        chk("issue_index", ddr_index, idx);
        if (ch == CH_ST) begin
            chk("issue_mask", ddr_opstore_write_mask, st_mask);
            chk("issue_data", ddr_opstore_write_data, st_data);
        end
        tick();
        chk("ce_one_cycle", ddr_chip_enable, 1'b0);
        for (int i = 0; i < lat; i++) begin
            if (flush && i == 0) pc_flush = 1'b1;
            tick();
            pc_flush = 1'b0;
        end
        chk("payload_stable", ddr_index, idx);
        chk("no_done_in_wait", {st_done, ld_done, pc_done}, 3'b000);
        ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        chk("st_done", st_done, 1'(ch == CH_ST));
        chk("ld_done", ld_done, 1'(ch == CH_LD));
        chk("pc_done", pc_done, 1'((ch == CH_PC) && !flush));
        if (ch == CH_LD) chk("ld_data", ld_data, exp_rd);
        if (ch == CH_PC) chk("pc_line", pc_line, exp_rd);
        if (drop) begin
            case (ch)
                CH_ST:   st_req = 1'b0;
                CH_LD:   ld_req = 1'b0;
                default: pc_req = 1'b0;
            endcase
        end
        tick();
        chk("done_one_cycle", {st_done, ld_done, pc_done}, 3'b000);
    endtask

    logic [LINE_W-1:0] line_a5, line_3c;
    logic [DATA_W-1:0] ld_val;

    initial begin
        reset_n = 1'b1;
        {pc_req, pc_flush, ld_req, st_req, ddr_operation_done} = '0;
        pc_index = '0; ld_index = '0; st_index = '0;
        st_mask = '0; st_data = '0;
        ddr_opload_read_data = '0; ddr_pc_read_inst = '0;
        ddr_ready = 1'b1;
        line_a5 = {64{8'hA5}};
        line_3c = {64{8'h3C}};
        ld_val  = 64'hDEADBEEF_CAFEF00D;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_ctrl", {ddr_chip_enable, ddr_write_enable, ddr_burst_mode}, 3'b000);
        chk("rst_dones", {st_done, ld_done, pc_done}, 3'b000);
        chk("rst_payload", {ddr_index, ddr_opstore_write_mask, ddr_opstore_write_data}, '0);
        chk("rst_capture", {ld_data, pc_line}, '0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // DDR not ready: no grant
        ddr_ready = 1'b0;
        st_req = 1'b1; st_index = 19'h00010; st_mask = 64'hFF; st_data = 64'h1122334455667788;
        tick(); tick(); tick();
        chk("not_ready_no_ce", ddr_chip_enable, 1'b0);
        chk("not_ready_idle", dut.state_q, IDLE);
        ddr_ready = 1'b1;
        serve(CH_ST, 19'h00010, 4, 1'b0, 1'b1, '0);

        // Instruction burst
        pc_req = 1'b1; pc_index = 19'h00040; ddr_pc_read_inst = line_a5;
        serve(CH_PC, 19'h00040, 3, 1'b0, 1'b1, line_a5);

        // Simultaneous requests: st, ld, pc in order
        st_req = 1'b1; st_index = 19'h00100; st_mask = 64'hF0F0; st_data = 64'h0123456789ABCDEF;
        ld_req = 1'b1; ld_index = 19'h00200;
        pc_req = 1'b1; pc_index = 19'h00300;
        ddr_opload_read_data = ld_val; ddr_pc_read_inst = line_3c;
        serve(CH_ST, 19'h00100, 2, 1'b0, 1'b1, '0);
        serve(CH_LD, 19'h00200, 2, 1'b0, 1'b1, {448'b0, ld_val});
        serve(CH_PC, 19'h00300, 2, 1'b0, 1'b1, line_3c);
        chk("ld_data_hold", ld_data, ld_val);

        // Flushed pc, then a load served normally
        pc_req = 1'b1; pc_index = 19'h00044; ddr_pc_read_inst = line_a5;
        tick();
        ld_req = 1'b1; ld_index = 19'h00055; ddr_opload_read_data = 64'h5555AAAA5555AAAA;
        serve(CH_PC, 19'h00044, 3, 1'b1, 1'b1, line_a5);
        serve(CH_LD, 19'h00055, 1, 1'b0, 1'b1, {448'b0, 64'h5555AAAA5555AAAA});
        chk("pc_line_hold", pc_line, line_a5);

        // Reset during WAIT of a load, then a late done
        ld_req = 1'b1; ld_index = 19'h00077;
        tick(); tick();
        chk("pre_rst_wait", dut.state_q, WAIT);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_state", dut.state_q, IDLE);
        chk("rst_wait_outs", {ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index, ld_data}, '0);
        ld_req = 1'b0;
        tick();
        reset_n = 1'b1;
        ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        chk("late_done_no_ld_done", ld_done, 1'b0);
        chk("late_done_idle", dut.state_q, IDLE);
        tick();
        chk("late_done_no_ce", ddr_chip_enable, 1'b0);

        // st and ld held continuously
        st_req = 1'b1; st_index = 19'h00011; st_mask = 64'h1; st_data = 64'h2;
        ld_req = 1'b1; ld_index = 19'h00022; ddr_opload_read_data = 64'h77;
`ifdef DDR_ARB_ROUND_ROBIN_EN
        serve(CH_ST, 19'h00011, 1, 1'b0, 1'b0, '0);
        serve(CH_LD, 19'h00022, 1, 1'b0, 1'b0, {448'b0, 64'h77});
        serve(CH_ST, 19'h00011, 1, 1'b0, 1'b0, '0);
        serve(CH_LD, 19'h00022, 1, 1'b0, 1'b0, {448'b0, 64'h77});
`else
        serve(CH_ST, 19'h00011, 1, 1'b0, 1'b0, '0);
        serve(CH_ST, 19'h00011, 1, 1'b0, 1'b0, '0);
        serve(CH_ST, 19'h00011, 1, 1'b0, 1'b1, '0);
        serve(CH_LD, 19'h00022, 1, 1'b0, 1'b1, {448'b0, 64'h77});
`endif
        st_req = 1'b0; ld_req = 1'b0;
        tick(); tick();
        chk("final_idle", dut.state_q, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
